// File: rtl/program_loader.sv
// Program memory write-port sequencer: loads a length/data/checksum image
// from the UART byte stream, or zero-fills memory, holding the CPU meanwhile.
module program_loader #(
    parameter int MEM_BYTES      = 1024,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clear_req,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        mem_write_enable,
    output logic [7:0]  mem_write_data,
    output logic [31:0] mem_write_address,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] MEM_COUNT = CW'(MEM_BYTES);
    localparam logic [31:0]   MEM_LIMIT = 32'(MEM_BYTES);
    localparam logic [31:0]   TMO_LIMIT = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LEN,
        DATA,
        CSUM
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] count, count_n;
    logic [1:0]    len_idx, len_idx_n;
    logic [31:0]   len_q, len_n;
    logic [7:0]    csum, csum_n;
    logic [31:0]   tmo, tmo_n;
    logic          we_q, we_n;
    logic [7:0]    wdata_q, wdata_n;
    logic [AW-1:0] waddr_q, waddr_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;
    logic          error_q, error_n;
    logic [31:0]   len_full;
    logic          timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            len_idx <= '0;
            len_q   <= '0;
            csum    <= '0;
            tmo     <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            waddr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            len_idx <= len_idx_n;
            len_q   <= len_n;
            csum    <= csum_n;
            tmo     <= tmo_n;
            we_q    <= we_n;
            wdata_q <= wdata_n;
            waddr_q <= waddr_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            error_q <= error_n;
        end
    end

    // Length bytes arrive little-endian, so each new byte shifts in from the top.
    assign len_full    = {rx_data, len_q[31:8]};
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && !rx_valid && ((tmo + 32'd1) == TMO_LIMIT);

    always_comb begin
        state_n   = state;
        count_n   = count;
        len_idx_n = len_idx;
        len_n     = len_q;
        csum_n    = csum;
        tmo_n     = tmo;
        we_n      = 1'b0;
        wdata_n   = wdata_q;
        waddr_n   = waddr_q;
        done_n    = 1'b0;
        error_n   = error_q;

        if (state == LEN || state == DATA || state == CSUM) begin
            if (rx_valid || TIMEOUT_CYCLES == 0) begin
                tmo_n = '0;
            end else begin
                tmo_n = tmo + 32'd1;
            end
        end

        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_n = CLEAR;
                    we_n    = 1'b1;
                    wdata_n = 8'h00;
                    waddr_n = '0;
                    count_n = CW'(1);
                    error_n = 1'b0;
                end else if (start) begin
                    state_n   = LEN;
                    len_idx_n = '0;
                    len_n     = '0;
                    tmo_n     = '0;
                    error_n   = 1'b0;
                end
            end

            // count holds the next address to zero; reaching MEM_BYTES means all written.
            CLEAR: begin
                if (count == MEM_COUNT) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    count_n = '0;
                end else begin
                    we_n    = 1'b1;
                    wdata_n = 8'h00;
                    waddr_n = count[AW-1:0];
                    count_n = count + CW'(1);
                end
            end

            LEN: begin
                if (rx_valid) begin
                    len_n     = len_full;
                    len_idx_n = len_idx + 2'd1;
                    if (len_idx == 2'd3) begin
                        if (len_full == 32'd0 || len_full > MEM_LIMIT) begin
                            state_n = IDLE;
                            error_n = 1'b1;
                        end else begin
                            state_n = DATA;
                            count_n = '0;
                            csum_n  = '0;
                        end
                    end
                end else if (timeout_hit) begin
                    state_n = IDLE;
                    error_n = 1'b1;
                end
            end

            // len_q is known to be 1..MEM_BYTES here, so its low CW bits hold it exactly.
            DATA: begin
                if (rx_valid) begin
                    we_n    = 1'b1;
                    wdata_n = rx_data;
                    waddr_n = count[AW-1:0];
                    count_n = count + CW'(1);
                    csum_n  = csum + rx_data;
                    if ((count + CW'(1)) == len_q[CW-1:0]) begin
                        state_n = CSUM;
                    end
                end else if (timeout_hit) begin
                    state_n = IDLE;
                    error_n = 1'b1;
                end
            end

            CSUM: begin
                if (rx_valid) begin
                    state_n = IDLE;
                    if (rx_data == csum) begin
                        done_n = 1'b1;
                    end else begin
                        error_n = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_n = IDLE;
                    error_n = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    assign mem_write_enable  = we_q;
    assign mem_write_data    = wdata_q;
    assign mem_write_address = {{(32-AW){1'b0}}, waddr_q};
    assign busy              = busy_q;
    assign cpu_hold          = busy_q;
    assign done              = done_q;
    assign error             = error_q;

endmodule

// File: doc/program_loader.md
# program_loader

Sequencer that owns the write port of the byte-addressed program memory. It loads a program image received as a byte stream from the UART receiver, and zero-fills the memory on request. While it holds the memory, it keeps the CPU stalled through `cpu_hold`. It sits between the UART RX block, the program memory write port and the core's stall/reset logic.

## Interface
Parameters:
- `MEM_BYTES`, 1024: program memory size in bytes; maximum legal image length.
- `TIMEOUT_CYCLES`, 1_000_000: idle-cycle limit between received bytes in a load session; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse; begin a load session.
- `clear_req`  in  1  one-cycle pulse; zero-fill the whole memory.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` holds a received byte.
- `rx_data`  in  8  received byte.
- `mem_write_enable`  out  1  write strobe to program memory.
- `mem_write_data`  out  8  byte to write.
- `mem_write_address`  out  32  byte address; bits above `$clog2(MEM_BYTES)` are always 0.
- `cpu_hold`  out  1  high while the loader owns memory; the CPU must stall/reset.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse on successful completion of a load or clear.
- `error`  out  1  sticky failure flag.

## Operation
- All outputs are registered. Reset values are 0 for every output, the state is IDLE and all counters are 0.
- States: IDLE, CLEAR, LEN, DATA, CSUM.
- IDLE:
  - If `clear_req` is high, go to CLEAR. This wins if `start` is high in the same cycle.
  - Else if `start` is high, go to LEN.
  - Either accepted request clears `error`.
  - `rx_valid` is ignored in IDLE.
- `start` and `clear_req` are ignored in every state except IDLE.
- CLEAR:
  - Writes 0x00 to addresses 0..MEM_BYTES-1, one per cycle, in ascending order.
  - After address MEM_BYTES-1 is written, return to IDLE with a `done` pulse.
  - `rx_valid` is ignored.
- LEN:
  - Collects 4 bytes as the 32-bit length N, little-endian (first byte = N[7:0]).
  - If N==0 or N>MEM_BYTES, set `error` and go to IDLE with no memory writes.
  - Otherwise go to DATA with the address counter and checksum at 0.
- DATA:
  - Each `rx_valid` byte is written at the current address. The address then increments and the byte is added to an 8-bit checksum (mod 256).
  - After byte N has been received, go to CSUM.
- CSUM:
  - The next `rx_valid` byte is compared with the checksum.
  - On a match, return to IDLE with a `done` pulse.
  - On a mismatch, set `error` and return to IDLE. Bytes already written stay in memory.
- Timeout applies in LEN, DATA and CSUM:
  - A counter clears on every `rx_valid` and on entry to the state.
  - When it reaches TIMEOUT_CYCLES, set `error` and go to IDLE.
- `done` and `error` are never both set by the same event. `done` does not clear `error` (`error` cannot be set in a session that ends with `done`).
- `cpu_hold` equals `busy`. `mem_write_enable` is 0 outside CLEAR and DATA writes.

## Timing
- `start`/`clear_req` sampled high at edge k: `busy` and `cpu_hold` are high from cycle k+1.
- CLEAR writes:
  - The write to address 0 has `mem_write_enable` high in cycle k+1.
  - Address MEM_BYTES-1 is written in cycle k+MEM_BYTES.
  - `done` is high, and `busy`/`cpu_hold` are low, in cycle k+MEM_BYTES+1.
- Data write latency is one cycle: a DATA-state `rx_valid` sampled at edge t produces `mem_write_enable`=1 with that byte and address during cycle t+1. Back-to-back `rx_valid` on consecutive cycles is supported, giving one write per cycle.
- The final `rx_valid` (checksum byte) sampled at edge t: in cycle t+1, `done` or `error` is set, `busy` and `cpu_hold` are 0, and the state is IDLE. The last data write has already completed.
- Length check: the 4th length byte sampled at edge t means the state in cycle t+1 is DATA, or IDLE with `error`=1.
- `rst` asserted at any point, including mid-CLEAR or mid-DATA: all outputs go to 0 immediately. `mem_write_enable` drops asynchronously. The partial image is left as written.

## Test plan
- Reset: assert `rst` mid-DATA after 3 payload bytes → `mem_write_enable`, `cpu_hold`, `busy`, `done`, `error` are all 0 that cycle; after release the state is IDLE, and `rx_valid` pulses cause no writes.
- Good load:
  - Stimulus: `start`, then bytes 03 00 00 00, AA BB CC, checksum 0x31.
  - Memory writes: 0→AA, 1→BB, 2→CC, each one cycle after its `rx_valid`.
  - Completion: `done` is high for one cycle, 1 cycle after the checksum byte; `cpu_hold` is low in that cycle; `error`=0.
- Bad checksum: same image with checksum 0x30 → 3 writes occur; then `error`=1, `done`=0, IDLE; `error` stays 1 until the next `start`, which clears it.
- Length bounds:
  - N=0 (00 00 00 00) → `error` with zero writes.
  - N=MEM_BYTES+1 → `error` with zero writes.
  - N=MEM_BYTES with back-to-back bytes → MEM_BYTES writes to 0..MEM_BYTES-1, then `done`.
- Clear and arbitration: `start` and `clear_req` in the same cycle → CLEAR runs, MEM_BYTES zero writes on consecutive cycles, `done` at k+MEM_BYTES+1. `start` and `rx_valid` during CLEAR have no effect.
- Timeout: with TIMEOUT_CYCLES=16, send `start` and 2 length bytes, then stall → `error`=1 and IDLE 16 cycles after the last byte. With TIMEOUT_CYCLES=0 the session waits indefinitely.
